// File: rtl/bayer_line_scheduler.sv
// Bayer line-buffer scheduler: rotates four line RAMs through fill/stream/flush
// of a frame and drives the shared RAM address plus the debayer output valid.
module bayer_line_scheduler #(
    parameter int ADDR_WIDTH = 11,
    parameter int FLUSH_EN   = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  frame_valid_i,
    input  logic                  line_valid_i,
    input  logic                  data_valid_i,
    input  logic [1:0]            cfg_pattern_i,
    output logic [3:0]            wr_en_o,
    output logic [1:0]            rd_center_o,
    output logic [ADDR_WIDTH-1:0] line_addr_o,
    output logic                  row_parity_o,
    output logic                  col_phase_o,
    output logic                  out_valid_o,
    output logic [11:0]           line_count_o,
    output logic [1:0]            state_o,
    output logic                  ovf_err_o
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic                  r_lv_q;
    logic                  r_fv_q;
    logic                  r_line_act;
    logic                  r_row_parity;
    logic                  r_ovf;
    logic [3:0]            r_wr_sel;
    logic [1:0]            r_pat;
    logic [1:0]            r_stored;
    logic [1:0]            r_vld_pipe;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_last_len;
    logic [11:0]           r_line_count;

    logic        w_lv_rise, w_lv_fall, w_fv_rise, w_fv_fall;
    logic        w_active, w_addr_max, w_word, w_acc;
    logic        w_line_start, w_line_end, w_frame_start;
    logic        w_flush_go, w_vld_in;
    logic [1:0]  w_wr_idx;
    logic [11:0] w_cnt_nxt;

    assign w_lv_rise  = line_valid_i & ~r_lv_q;
    assign w_lv_fall  = ~line_valid_i & r_lv_q;
    assign w_fv_rise  = frame_valid_i & ~r_fv_q;
    assign w_fv_fall  = ~frame_valid_i & r_fv_q;
    assign w_active   = (r_state == S_FILL) || (r_state == S_STREAM);
    assign w_addr_max = &r_addr;
    assign w_word     = data_valid_i & line_valid_i & w_active;
    // The last address is never written: reaching it marks the line as overlong.
    assign w_acc      = w_word & ~w_addr_max;

    assign w_line_start  = w_lv_rise & frame_valid_i & w_active;
    assign w_line_end    = w_lv_fall & r_line_act & w_active;
    assign w_frame_start = w_fv_rise & ((r_state == S_IDLE) || (r_state == S_FLUSH));
    assign w_flush_go    = (r_state == S_FLUSH) & ~w_fv_rise;
    assign w_vld_in      = ((r_state == S_STREAM) & data_valid_i & line_valid_i) | w_flush_go;

    assign w_cnt_nxt = (w_line_end && r_line_count != 12'hFFF) ? r_line_count + 12'd1
                                                               : r_line_count;

    always_comb begin
        case (r_wr_sel)
            4'b0001: w_wr_idx = 2'd0;
            4'b0010: w_wr_idx = 2'd1;
            4'b0100: w_wr_idx = 2'd2;
            default: w_wr_idx = 2'd3;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= S_IDLE;
            r_lv_q       <= 1'b0;
            r_fv_q       <= 1'b0;
            r_line_act   <= 1'b0;
            r_row_parity <= 1'b0;
            r_ovf        <= 1'b0;
            r_wr_sel     <= 4'b1000;
            r_pat        <= 2'b00;
            r_stored     <= 2'd0;
            r_vld_pipe   <= 2'b00;
            r_addr       <= '0;
            r_last_len   <= '0;
            r_line_count <= 12'd0;
        end else begin
            r_lv_q       <= line_valid_i;
            r_fv_q       <= frame_valid_i;
            r_vld_pipe   <= {r_vld_pipe[0], w_vld_in};
            r_line_count <= w_cnt_nxt;
            r_row_parity <= w_cnt_nxt[0] ^ r_pat[1];

            if (w_line_start) begin
                r_wr_sel   <= {r_wr_sel[2:0], r_wr_sel[3]};
                r_line_act <= 1'b1;
            end
            if (w_line_end) begin
                r_last_len <= r_addr;
                r_line_act <= 1'b0;
                if (r_stored != 2'd2)
                    r_stored <= r_stored + 2'd1;
            end
            if (w_word && w_addr_max)
                r_ovf <= 1'b1;

            if (!line_valid_i)
                r_addr <= '0;
            else if (w_acc)
                r_addr <= r_addr + ADDR_ONE;

            case (r_state)
                S_IDLE: begin
                    if (w_fv_rise)
                        r_state <= S_FILL;
                end
                S_FILL: begin
                    if (w_fv_fall)
                        r_state <= S_IDLE;
                    else if (w_line_start && r_stored == 2'd2)
                        r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_fv_fall) begin
                        r_state <= (FLUSH_EN != 0 && r_last_len != '0) ? S_FLUSH : S_IDLE;
                        r_addr  <= '0;
                    end
                end
                S_FLUSH: begin
                    // Replay the final line from RAM; a new frame preempts it at once.
                    if (w_fv_rise) begin
                        r_state <= S_FILL;
                        r_addr  <= '0;
                    end else if (r_addr == r_last_len - ADDR_ONE) begin
                        r_state <= S_IDLE;
                        r_addr  <= '0;
                    end else begin
                        r_addr <= r_addr + ADDR_ONE;
                    end
                end
            endcase

            if (w_frame_start) begin
                r_line_count <= 12'd0;
                r_row_parity <= cfg_pattern_i[1];
                r_ovf        <= 1'b0;
                r_stored     <= 2'd0;
                r_pat        <= cfg_pattern_i;
                r_line_act   <= 1'b0;
            end
        end
    end

    // During flush the centre row is the last RAM written; otherwise two ahead of the writer.
    assign rd_center_o  = (r_state == S_FLUSH) ? w_wr_idx : w_wr_idx + 2'd2;
    assign wr_en_o      = r_wr_sel & {4{w_acc}};
    assign line_addr_o  = r_addr;
    assign row_parity_o = r_row_parity;
    assign col_phase_o  = r_pat[0];
    assign out_valid_o  = r_vld_pipe[1];
    assign line_count_o = r_line_count;
    assign state_o      = r_state;
    assign ovf_err_o    = r_ovf;
endmodule
